sk16_sub_pipe: RTL and testbench
================================

SK16_SUB_PIPE -- requirements
Module: sk16_sub_pipe

Interface
REQ-001 Parameters SHALL be: none; operand width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  synchronous discard of all in-flight operations.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  16  minuend, unsigned or two's complement.
REQ-008 b  input  16  subtrahend.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 diff  output  16  a - b mod 2^16.
REQ-012 borrow  output  1  1 when a < b unsigned.
REQ-013 ovf  output  1  signed overflow of a - b.
REQ-014 zero  output  1  1 when diff == 0.

Function
REQ-015 Subtraction SHALL be a + ~b + 1: per-bit g = a & ~b and p = a ^ ~b, carry-in 1, Sklansky prefix tree (4 levels of (G,P) combine, spans 1/2/4/8).
REQ-016 Pipeline SHALL have 3 register stages: S1 holds g, p, a[15], b[15]; S2 holds group (G,P) after prefix levels 1-2; S3 holds the final outputs after levels 3-4 and the sum XOR.
REQ-017 Latency SHALL be exactly 3 cycles from input handshake (in_valid & in_ready) to out_valid, with no stalls.
REQ-018 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-019 Each stage SHALL have a valid bit; stage k SHALL load when it is empty or its content moves to stage k+1 (S3 moves when out_ready = 1).
REQ-020 in_ready SHALL equal !flush & (!S1_valid | S1 advancing), combinationally.
REQ-021 Bubbles SHALL collapse: an empty downstream stage SHALL load even while the output is stalled.
REQ-022 While out_valid = 1 and out_ready = 0, diff/borrow/ovf/zero SHALL hold stable.
REQ-023 Results SHALL emerge in acceptance order, with no loss or duplication.
REQ-024 The carry-out (bit-16 carry) SHALL be computed, and borrow SHALL equal its inverse.
REQ-025 ovf SHALL equal (a[15] != b[15]) & (diff[15] != a[15]).
REQ-026 zero SHALL be registered in S3 alongside diff.
REQ-027 flush = 1 SHALL clear all three valid bits at the next edge.
REQ-028 With flush = 1, in_ready SHALL be 0, so no operand is accepted that cycle.
REQ-029 Flush SHALL override out_ready, and out_valid SHALL be 0 in the cycle after flush.
REQ-030 A data register whose valid bit is 0 SHALL carry don't-care contents, except the S3 outputs (see REQ-032).

Reset
REQ-031 While rst_n = 0: all valid bits SHALL be 0, in_ready SHALL be 0, and out_valid SHALL be 0.
REQ-032 While rst_n = 0: diff, borrow, ovf and zero SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight operations immediately (asynchronously).
REQ-034 After rst_n deasserts, in_ready SHALL be 1 in the first cycle, provided flush = 0.

Verification
REQ-035 a=0x0005, b=0x0003, out_ready=1 -> 3 cycles later: diff=0x0002, borrow=0, ovf=0, zero=0.
REQ-036 a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, zero=0.
REQ-037 a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, borrow=0; then a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, borrow=1.
REQ-038 a=b=0x1234 -> diff=0x0000, zero=1, borrow=0; a=0x0000, b=0x0000 -> zero=1.
REQ-039 Backpressure case:
- stimulus: 5 back-to-back ops (a=i, b=0 for i=1..5); out_ready=0 for cycles 3-8, then 1.
- response: in_ready drops once 3 ops are held; results 1..5 appear in order with none lost.
- also: 10,000 random ops with random out_ready, checked against a reference model.
REQ-040 Flush and reset case:
- stimulus: 3 ops in flight, flush pulsed 1 cycle.
- response: out_valid=0 next cycle; a new op issued afterwards emerges after 3 cycles.
- repeat using rst_n low mid-stream; response: all outputs 0 immediately.

Source files
------------

// File: rtl/sk16_sub_pipe.sv
// 16-bit subtractor (a + ~b + 1) using a Sklansky prefix tree split over a
// 3-stage valid/ready pipeline; stages load when empty or when their content moves on.
module sk16_sub_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        borrow,
  output logic        ovf,
  output logic        zero
);

  logic        s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [15:0] s1_g_reg, s1_p_reg;
  logic        s1_a15_reg, s1_b15_reg;
  logic [15:0] s2_g_reg, s2_gp_reg, s2_p_reg;
  logic        s2_a15_reg, s2_b15_reg;
  logic [15:0] s3_diff_reg;
  logic        s3_borrow_reg, s3_ovf_reg, s3_zero_reg;

  logic s1_load, s2_load, s3_load;

  // A stage may load when it is empty or its content is leaving this edge.
  assign s3_load  = !s3_valid_reg || out_ready;
  assign s2_load  = !s2_valid_reg || s3_load;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = rst_n && !flush && s1_load;

  // Prefix levels 1-2 read S1, levels 3-4 read the S2 registers.
  logic [15:0] lg [0:4];
  logic [15:0] lp [0:3];
  logic [15:0] sg [1:4];
  logic [15:0] sp [1:4];

  // Carry-in of 1 folds into bit 0 as a generate; its group propagate is then moot.
  assign lg[0] = {s1_g_reg[15:1], s1_g_reg[0] | s1_p_reg[0]};
  assign lp[0] = {s1_p_reg[15:1], 1'b0};

  for (genvar li = 1; li <= 4; li++) begin : g_lvl
    localparam int S = 1 << (li - 1);
    if (li == 3) begin : g_src_reg
      assign sg[li] = s2_g_reg;
      assign sp[li] = s2_gp_reg;
    end else begin : g_src_comb
      assign sg[li] = lg[li-1];
      assign sp[li] = lp[li-1];
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
      if (((gi / S) % 2) == 1) begin : g_comb
        localparam int J = (gi / (2 * S)) * (2 * S) + S - 1;
        assign lg[li][gi] = sg[li][gi] | (sp[li][gi] & sg[li][J]);
        if (li < 4) begin : g_p
          assign lp[li][gi] = sp[li][gi] & sp[li][J];
        end
      end else begin : g_pass
        assign lg[li][gi] = sg[li][gi];
        if (li < 4) begin : g_p
          assign lp[li][gi] = sp[li][gi];
        end
      end
    end
  end

  logic [15:0] sum_c;
  logic        cout_c;
  assign sum_c  = s2_p_reg ^ {lg[4][14:0], 1'b1};
  assign cout_c = lg[4][15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s3_diff_reg   <= 16'h0000;
      s3_borrow_reg <= 1'b0;
      s3_ovf_reg    <= 1'b0;
      s3_zero_reg   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
        s3_valid_reg <= 1'b0;
      end else begin
        if (s1_load) s1_valid_reg <= in_valid;
        if (s2_load) s2_valid_reg <= s1_valid_reg;
        if (s3_load) s3_valid_reg <= s2_valid_reg;
      end
      if (!flush && s2_valid_reg && s3_load) begin
        s3_diff_reg   <= sum_c;
        s3_borrow_reg <= !cout_c;
        s3_ovf_reg    <= (s2_a15_reg != s2_b15_reg) && (sum_c[15] != s2_a15_reg);
        s3_zero_reg   <= (sum_c == 16'h0000);
      end
    end
  end

  // Stage 1/2 payload is don't-care while its valid bit is low, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_g_reg   <= a & ~b;
      s1_p_reg   <= a ^ ~b;
      s1_a15_reg <= a[15];
      s1_b15_reg <= b[15];
    end
    if (s1_valid_reg && s2_load) begin
      s2_g_reg   <= lg[2];
      s2_gp_reg  <= lp[2];
      s2_p_reg   <= s1_p_reg;
      s2_a15_reg <= s1_a15_reg;
      s2_b15_reg <= s1_b15_reg;
    end
  end

  assign out_valid = s3_valid_reg;
  assign diff      = s3_diff_reg;
  assign borrow    = s3_borrow_reg;
  assign ovf       = s3_ovf_reg;
  assign zero      = s3_zero_reg;

endmodule

// File: tb/tb_sk16_sub_pipe.sv
// Directed and randomized checks of sk16_sub_pipe: results, latency, throughput,
// backpressure, flush and asynchronous reset.
module tb_sk16_sub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready, out_valid, borrow, ovf, zero;
  logic [15:0] diff;

  always #5 clk = ~clk;

  sk16_sub_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf), .zero(zero)
  );

  logic [18:0] expq [$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          out_cyc = 0;
  int          n_out = 0;
  string       cur_tag = "init";
  logic        hold_v = 1'b0;
  logic [18:0] hold_val = '0;

  // {diff, borrow, ovf, zero}
  logic [15:0] va [10] = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'h1234,
                           16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 16'h8000};
  logic [15:0] vb [10] = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h1234,
                           16'h0000, 16'h0001, 16'h0001, 16'h8000, 16'h7FFF};
  logic [18:0] ve [10] = '{{16'h0002, 3'b000}, {16'hFFFE, 3'b100}, {16'h7FFF, 3'b010},
                           {16'h8000, 3'b110}, {16'h0000, 3'b001}, {16'h0000, 3'b001},
                           {16'hFFFE, 3'b000}, {16'hFFFF, 3'b100}, {16'h8001, 3'b110},
                           {16'h0001, 3'b010}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] e;
    e = {1'b0, x} - {1'b0, y};
    return {e[15:0], e[16], (x[15] != y[15]) && (e[15] != x[15]), e[15:0] == 16'h0000};
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick(output bit acc);
    logic [18:0] obs;
    logic [18:0] e;
    #1;
    obs = {diff, borrow, ovf, zero};
    if (hold_v) chk({cur_tag, "_hold"}, {out_valid, obs}, {1'b1, hold_val});
    hold_v   = out_valid && !out_ready && !flush;
    hold_val = obs;
    acc = in_valid && in_ready;
    if (acc) acc_cyc = cyc;
    if (out_valid && out_ready && !flush) begin
      out_cyc = cyc;
      n_out++;
      if (expq.size() == 0) chk({cur_tag, "_spurious_out"}, 1, 0);
      else begin
        e = expq.pop_front();
        chk(cur_tag, obs, e);
        $display("%s: out diff=%h borrow=%b ovf=%b zero=%b", cur_tag, diff, borrow, ovf, zero);
      end
    end
    if (flush) expq.delete();
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [18:0] e);
    bit acc;
    acc = 1'b0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      tick(acc);
      if (acc) expq.push_back(e);
    end
    in_valid = 1'b0;
    if (!acc) chk({cur_tag, "_issue_timeout"}, 0, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 60 && expq.size() != 0; k++) tick(acc);
    chk({cur_tag, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int t0, t1, nxt, n0, nacc;
    bit saw_drop;

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {diff, borrow, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Directed vectors
    out_ready = 1'b1;
    cur_tag = "dir";
    issue(va[0], vb[0], ve[0]);
    drain();
    chk("dir_latency", out_cyc - acc_cyc, 3);
    t0 = 0;
    for (int i = 1; i < 10; i++) begin
      issue(va[i], vb[i], ve[i]);
      if (i == 1) t0 = acc_cyc;
    end
    t1 = acc_cyc;
    drain();
    chk("dir_throughput", t1 - t0, 8);

    // Backpressure: 5 ops, out_ready low in cycles 3..8
    cur_tag = "bp";
    nxt = 1;
    saw_drop = 1'b0;
    n0 = n_out;
    for (int k = 1; k <= 30; k++) begin
      out_ready = !(k >= 3 && k <= 8);
      in_valid = (nxt <= 5);
      a = 16'(nxt);
      b = 16'h0000;
      #1;
      if (in_valid && !in_ready && !saw_drop) begin
        saw_drop = 1'b1;
        chk("bp_held_at_drop", expq.size(), 3);
      end
      tick(acc);
      if (acc) begin
        expq.push_back({16'(nxt), 3'b000});
        nxt++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("bp_in_ready_dropped", saw_drop, 1);
    chk("bp_count", n_out - n0, 5);

    // Flush with 3 ops in flight
    cur_tag = "fl";
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(16'(16'h0100 + i), 16'h0001, model(16'(16'h0100 + i), 16'h0001));
    chk("fl_out_valid_before", out_valid, 1);
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick(acc);
    chk("fl_accepted", acc, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_out_valid_after", out_valid, 0);
    out_ready = 1'b1;
    issue(16'h0042, 16'h0040, {16'h0002, 3'b000});
    drain();
    chk("fl_latency", out_cyc - acc_cyc, 3);

    // Asynchronous reset mid-stream
    cur_tag = "rst";
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(16'h0F00, 16'(i), model(16'h0F00, 16'(i)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_outputs", {diff, borrow, ovf, zero}, 0);
    expq.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_in_ready_after", in_ready, 1);
    out_ready = 1'b1;
    issue(16'h0000, 16'h0000, {16'h0000, 3'b001});
    drain();
    chk("rst_latency", out_cyc - acc_cyc, 3);

    // Random traffic against the reference model
    cur_tag = "rnd";
    nacc = 0;
    for (int k = 0; k < 60000 && nacc < 10000; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = 16'($urandom);
        b = 16'($urandom);
        in_valid = 1'b1;
      end
      tick(acc);
      if (acc) begin
        expq.push_back(model(a, b));
        nacc++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rnd_accepted", nacc, 10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
